alu_scheduler: RTL

ALU_SCHEDULER -- requirements
Module: alu_scheduler

---
 rtl/alu_scheduler.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/alu_scheduler.sv
// Two-requester front end for a shared, externally pipelined ALU.
// Round-robin grant, per-opcode EXEC latency, one-cycle response pulse.
module alu_scheduler #(
    parameter int unsigned ADD_LAT   = 2,
    parameter int unsigned LOGIC_LAT = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ0_VALID,
    output logic       REQ0_READY,
    input  logic [2:0] REQ0_OP,
    input  logic [7:0] REQ0_A,
    input  logic [7:0] REQ0_B,
    input  logic       REQ1_VALID,
    output logic       REQ1_READY,
    input  logic [2:0] REQ1_OP,
    input  logic [7:0] REQ1_A,
    input  logic [7:0] REQ1_B,
    output logic [2:0] ALU_OP,
    output logic [7:0] ALU_DATA1,
    output logic [7:0] ALU_DATA2,
    input  logic [7:0] ALU_RESULT,
    input  logic       ALU_ZERO,
    output logic       RSP0_VALID,
    output logic       RSP1_VALID,
    output logic [7:0] RSP_RESULT,
    output logic       RSP_ZERO,
    output logic       RSP_ERR,
    output logic       BUSY
);

    localparam logic [2:0] AddLatC   = 3'(ADD_LAT);
    localparam logic [2:0] LogicLatC = 3'(LOGIC_LAT);
    localparam logic [2:0] OpAdd     = 3'b001;
    localparam logic [2:0] OpBeq     = 3'b101;
    localparam logic [2:0] OpIll     = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StResp = 2'b10
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_last;
    logic       r_owner;
    logic [2:0] r_cnt;
    logic [2:0] r_alu_op;
    logic [7:0] r_alu_d1;
    logic [7:0] r_alu_d2;
    logic [7:0] r_rsp_result;
    logic       r_rsp_zero;
    logic       r_rsp_err;

    logic       w_idle;
    logic       w_grant0;
    logic       w_grant1;
    logic       w_hs;
    logic       w_sel;
    logic [2:0] w_op;
    logic [7:0] w_a;
    logic [7:0] w_b;
    logic [2:0] w_lat;
    logic       w_ill;
    logic       w_exec_done;

    assign w_idle = (r_state == StIdle);

    // Under contention the requester that did not win last time is served.
    assign w_grant0 = w_idle && REQ0_VALID && (!REQ1_VALID || r_last);
    assign w_grant1 = w_idle && REQ1_VALID && (!REQ0_VALID || !r_last);
    assign w_hs     = w_grant0 || w_grant1;
    assign w_sel    = w_grant1;

    assign w_op  = w_sel ? REQ1_OP : REQ0_OP;
    assign w_a   = w_sel ? REQ1_A  : REQ0_A;
    assign w_b   = w_sel ? REQ1_B  : REQ0_B;
    assign w_ill = (w_op == OpIll);
    assign w_lat = ((w_op == OpAdd) || (w_op == OpBeq)) ? AddLatC : LogicLatC;

    // A zero count can only appear through a bad parameter; treat it as last cycle.
    assign w_exec_done = (r_state == StExec) && (r_cnt <= 3'd1);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_hs) begin
                    w_state_nxt = w_ill ? StResp : StExec;
                end
            end
            StExec: begin
                if (w_exec_done) begin
                    w_state_nxt = StResp;
                end
            end
            StResp:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= StIdle;
            r_last  <= 1'b1;
            r_owner <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_last  <= w_sel;
                r_owner <= w_sel;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_cnt <= 3'd0;
        end else if (w_hs) begin
            r_cnt <= w_ill ? 3'd0 : w_lat;
        end else if (w_exec_done) begin
            r_cnt <= 3'd0;
        end else if (r_state == StExec) begin
            r_cnt <= r_cnt - 3'd1;
        end
    end

    // Illegal opcodes leave the ALU-facing registers untouched.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_alu_op <= 3'b000;
            r_alu_d1 <= 8'h00;
            r_alu_d2 <= 8'h00;
        end else if (w_hs && !w_ill) begin
            r_alu_op <= w_op;
            r_alu_d1 <= w_a;
            r_alu_d2 <= w_b;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_rsp_result <= 8'h00;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else if (w_hs && w_ill) begin
            r_rsp_result <= 8'h00;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b1;
        end else if (w_exec_done) begin
            r_rsp_result <= ALU_RESULT;
            r_rsp_zero   <= ALU_ZERO;
            r_rsp_err    <= 1'b0;
        end
    end

    assign REQ0_READY = w_grant0;
    assign REQ1_READY = w_grant1;
    assign ALU_OP     = r_alu_op;
    assign ALU_DATA1  = r_alu_d1;
    assign ALU_DATA2  = r_alu_d2;
    assign RSP0_VALID = (r_state == StResp) && !r_owner;
    assign RSP1_VALID = (r_state == StResp) && r_owner;
    assign RSP_RESULT = r_rsp_result;
    assign RSP_ZERO   = r_rsp_zero;
    assign RSP_ERR    = r_rsp_err;
    assign BUSY       = !w_idle;

endmodule
